// File: rtl/tm_input_pkg.sv
// Shared types and default timing for the TuringMachine input sequencer.
// Optional auto-repeat is enabled with TM_INPUT_AUTO_REPEAT_EN (see tm_input_sequencer).
package tm_input_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} seq_state_t;
    typedef enum logic {KIND_NEXT, KIND_DONE} seq_kind_t;

    localparam int unsigned DEF_DATA_W          = 6;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned DEF_SETUP_CYCLES    = 3;
    localparam int unsigned DEF_PULSE_CYCLES    = 2;
    localparam int unsigned DEF_GAP_CYCLES      = 2;
    localparam int unsigned DEF_REPEAT_CYCLES   = 1000000;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/tm_input_sequencer_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and rising-edge press strobe.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES > 1 ? DEBOUNCE_CYCLES : 2);

    logic             sync_meta;
    logic             sync_lvl;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_lvl  <= 1'b0;
            level     <= 1'b0;
            press     <= 1'b0;
            cnt       <= '0;
        end else begin
            sync_meta <= raw;
            sync_lvl  <= sync_meta;
            press     <= 1'b0;
            if (sync_lvl != level) begin
                // Flip on the last differing cycle; press fires only for a 0->1 flip.
                if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync_lvl;
                    press <= sync_lvl;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/tm_input_sequencer.sv
// Front-end turning switches and Next/Done buttons into setup/pulse/gap timed core transactions.
// Define TM_INPUT_AUTO_REPEAT_EN to make a held Next button re-trigger every REPEAT_CYCLES.
module tm_input_sequencer
    import tm_input_pkg::*;
#(
    parameter int unsigned DATA_W          = DEF_DATA_W,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned SETUP_CYCLES    = DEF_SETUP_CYCLES,
    parameter int unsigned PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int unsigned GAP_CYCLES      = DEF_GAP_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              btn_next,
    input  logic              btn_done,
    output logic [DATA_W-1:0] input_data,
    output logic              Next,
    output logic              Done,
    output logic              busy,
    output logic [1:0]        pend_out
);

    localparam int unsigned PH_MAX = max4(SETUP_CYCLES, PULSE_CYCLES, GAP_CYCLES, REPEAT_CYCLES);
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    logic [DATA_W-1:0] sw_meta;
    logic [DATA_W-1:0] sw_sync;

    logic next_level, next_press;
    logic done_level, done_press;
    logic next_pend, done_pend;
    logic rep_fire;

    seq_state_t state, state_d;
    seq_kind_t  kind, kind_d;
    logic [PH_W-1:0] ph, ph_d;
    logic load_data, clr_next, clr_done;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_next (
        .clock (clock),
        .reset (reset),
        .raw   (btn_next),
        .level (next_level),
        .press (next_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_done (
        .clock (clock),
        .reset (reset),
        .raw   (btn_done),
        .level (done_level),
        .press (done_press)
    );

`ifdef TM_INPUT_AUTO_REPEAT_EN
    localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES > 1 ? REPEAT_CYCLES : 2);

    logic [RPT_W-1:0] rpt_cnt;
    logic             unused_level;

    assign unused_level = done_level;
    assign rep_fire     = next_level && !next_press && (rpt_cnt == RPT_W'(REPEAT_CYCLES - 1));

    // Phase of the repeat is anchored to the initial press strobe.
    always_ff @(posedge clock) begin
        if (reset || !next_level || next_press || rep_fire) begin
            rpt_cnt <= '0;
        end else begin
            rpt_cnt <= rpt_cnt + RPT_W'(1);
        end
    end
`else
    logic unused_level;

    assign unused_level = next_level ^ done_level;
    assign rep_fire     = 1'b0;
`endif

    always_comb begin
        state_d   = state;
        kind_d    = kind;
        ph_d      = ph;
        load_data = 1'b0;
        clr_next  = 1'b0;
        clr_done  = 1'b0;
        case (state)
            IDLE: begin
                if (done_pend) begin
                    state_d   = SETUP;
                    kind_d    = KIND_DONE;
                    ph_d      = PH_W'(SETUP_CYCLES - 1);
                    load_data = 1'b1;
                    clr_done  = 1'b1;
                end else if (next_pend) begin
                    state_d   = SETUP;
                    kind_d    = KIND_NEXT;
                    ph_d      = PH_W'(SETUP_CYCLES - 1);
                    load_data = 1'b1;
                    clr_next  = 1'b1;
                end
            end
            SETUP: begin
                if (ph == '0) begin
                    state_d = PULSE;
                    ph_d    = PH_W'(PULSE_CYCLES - 1);
                end else begin
                    ph_d = ph - PH_W'(1);
                end
            end
            PULSE: begin
                if (ph == '0) begin
                    state_d = HOLD;
                    ph_d    = PH_W'(GAP_CYCLES - 1);
                end else begin
                    ph_d = ph - PH_W'(1);
                end
            end
            HOLD: begin
                if (ph == '0) begin
                    state_d = IDLE;
                    ph_d    = '0;
                end else begin
                    ph_d = ph - PH_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ph_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            kind       <= KIND_NEXT;
            ph         <= '0;
            sw_meta    <= '0;
            sw_sync    <= '0;
            input_data <= '0;
            Next       <= 1'b0;
            Done       <= 1'b0;
            busy       <= 1'b0;
            next_pend  <= 1'b0;
            done_pend  <= 1'b0;
        end else begin
            sw_meta <= sw_data;
            sw_sync <= sw_meta;
            state   <= state_d;
            kind    <= kind_d;
            ph      <= ph_d;
            if (load_data) begin
                input_data <= sw_sync;
            end
            // Outputs decode the next state so they stay glitch-free registers aligned with it.
            Next <= (state_d == PULSE) && (kind_d == KIND_NEXT);
            Done <= (state_d == PULSE) && (kind_d == KIND_DONE);
            busy <= (state_d != IDLE);
            // A press arriving while a flag is set (including its clear cycle) is dropped.
            next_pend <= clr_next ? 1'b0 : (next_pend | next_press | rep_fire);
            done_pend <= clr_done ? 1'b0 : (done_pend | done_press);
        end
    end

    assign pend_out = {done_pend, next_pend};

endmodule

// File: tb/tb_tm_input_sequencer.sv
// Scoreboard bench for tm_input_sequencer; stimulus queues expected transactions, a monitor checks strobes.
// Expected repeat count follows TM_INPUT_AUTO_REPEAT_EN.
module tb_tm_input_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] sw_data = '0;
    logic       btn_next = 1'b0;
    logic       btn_done = 1'b0;
    logic [5:0] input_data;
    logic       Next;
    logic       Done;
    logic       busy;
    logic [1:0] pend_out;

    tm_input_sequencer #(
        .DATA_W          (6),
        .DEBOUNCE_CYCLES (4),
        .SETUP_CYCLES    (3),
        .PULSE_CYCLES    (2),
        .GAP_CYCLES      (2),
        .REPEAT_CYCLES   (20)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sw_data    (sw_data),
        .btn_next   (btn_next),
        .btn_done   (btn_done),
        .input_data (input_data),
        .Next       (Next),
        .Done       (Done),
        .busy       (busy),
        .pend_out   (pend_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit is_done;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   rise_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic expect_txn(input bit is_done, input int data);
        exp_t e;
        e.is_done = is_done;
        e.data    = data;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitor: checks every strobe against the queue, plus setup latency and pulse width.
    bit   pn = 1'b0, pd = 1'b0, pb = 1'b0;
    int   width = 0;
    int   busy_rise = 0;
    exp_t me;

    initial begin
        forever begin
            @(negedge clock);
            if (busy && !pb) begin
                busy_rise = cyc;
                if (exp_q.size() > 0) chk("setup_data", int'(input_data), exp_q[0].data);
            end
            if ((Next && !pn) || (Done && !pd)) begin
                rise_q.push_back(cyc);
                chk("strobe_exclusive", int'(Next & Done), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", int'({Done, Next}), 0);
                end else begin
                    me = exp_q.pop_front();
                    chk("strobe_is_done", int'(Done), int'(me.is_done));
                    chk("strobe_data", int'(input_data), me.data);
                    chk("setup_to_strobe", cyc - busy_rise, 3);
                end
            end
            if (Next || Done) begin
                width++;
            end else if (pn || pd) begin
                if (!reset) chk("pulse_width", width, 2);
                width = 0;
            end
            pn = Next;
            pd = Done;
            pb = busy;
        end
    end

    int pl[$];
    int last_pend;
    int seen;
    bit found;

    initial begin
        // Reset state
        tick(3);
        @(negedge clock);
        chk("rst_input_data", int'(input_data), 0);
        chk("rst_next", int'(Next), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pend", int'(pend_out), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        tick(5);

        // Clean press
        sw_data = 6'd3;
        tick(4);
        expect_txn(1'b0, 3);
        btn_next = 1'b1;
        tick(10);
        btn_next = 1'b0;
        tick(30);

        // Glitch shorter than the debounce window
        btn_next = 1'b1;
        tick(3);
        btn_next = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            seen = seen | int'(busy);
        end
        chk("glitch_busy", seen, 0);
        tick(2);

        // Switch change during PULSE is ignored until the next transaction
        expect_txn(1'b0, 3);
        btn_next = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (Next) begin
                found = 1'b1;
                break;
            end
        end
        chk("wait_next_t3", int'(found), 1);
        sw_data = 6'd1;
        tick(4);
        btn_next = 1'b0;
        tick(25);
        chk("frozen_data", int'(input_data), 3);
        expect_txn(1'b0, 1);
        btn_next = 1'b1;
        tick(10);
        btn_next = 1'b0;
        tick(30);

        // Simultaneous presses: Done first, then Next right after HOLD
        expect_txn(1'b1, 1);
        expect_txn(1'b0, 1);
        rise_q.delete();
        pl.delete();
        last_pend = 0;
        btn_next = 1'b1;
        btn_done = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (int'(pend_out) != last_pend) begin
                last_pend = int'(pend_out);
                pl.push_back(last_pend);
            end
            if (i == 10) begin
                btn_next = 1'b0;
                btn_done = 1'b0;
            end
        end
        chk("pend_seq_len", pl.size(), 3);
        if (pl.size() == 3) begin
            chk("pend_seq_0", pl[0], 3);
            chk("pend_seq_1", pl[1], 1);
            chk("pend_seq_2", pl[2], 0);
        end
        chk("dual_rise_count", rise_q.size(), 2);
        if (rise_q.size() == 2) chk("rise_spacing", rise_q[1] - rise_q[0], 8);
        tick(10);

        // Reset during PULSE
        sw_data = 6'd2;
        tick(4);
        expect_txn(1'b0, 2);
        btn_next = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (Next) begin
                found = 1'b1;
                break;
            end
        end
        chk("wait_next_t5", int'(found), 1);
        btn_next = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_next", int'(Next), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_input_data", int'(input_data), 0);
        chk("midrst_pend", int'(pend_out), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        tick(20);
        chk("post_rst_idle", int'(busy), 0);
        expect_txn(1'b0, 2);
        btn_next = 1'b1;
        tick(10);
        btn_next = 1'b0;
        tick(30);

        // Long hold: auto-repeat when enabled, single transaction otherwise
        rise_q.delete();
        sw_data = 6'd5;
        tick(4);
`ifdef TM_INPUT_AUTO_REPEAT_EN
        for (int i = 0; i < 4; i++) expect_txn(1'b0, 5);
`else
        expect_txn(1'b0, 5);
`endif
        btn_next = 1'b1;
        tick(70);
        btn_next = 1'b0;
        tick(60);
`ifdef TM_INPUT_AUTO_REPEAT_EN
        chk("hold_strobe_count", rise_q.size(), 4);
        if (rise_q.size() == 4) chk("repeat_period", rise_q[2] - rise_q[1], 20);
`else
        chk("hold_strobe_count", rise_q.size(), 1);
`endif

        chk("final_busy", int'(busy), 0);
        chk("final_pend", int'(pend_out), 0);
        chk("pending_expectations", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
